fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the LEGv8 pipeline. It owns the program-counter register, drives the instruction-memory address, and captures the fetched word into the IF/ID pipeline register. It advances sequentially by 4, accepts branch redirects from later stages, and holds under downstream back-pressure. It sits directly upstream of the decode stage and is the block the PC `flopr` register is promoted into.

## Interface
Parameters:
- `N`, 64, PC and address width (must be ≥ 3)
- `RESET_PC`, 0, PC value loaded on reset (bits [1:0] must be 0)
- `NOP`, 32'hD503201F, instruction word placed in `id_instr` whenever the slot is empty

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low
- `imem_addr`  out  N  instruction-memory address; always equals the internal PC register
- `imem_rdata`  in  32  instruction at `imem_addr`; combinational, valid in the same cycle
- `redirect`  in  1  branch/exception redirect request from a later stage
- `redirect_pc`  in  N  redirect target address
- `id_ready`  in  1  decode stage accepts `id_*` this cycle
- `id_valid`  out  1  IF/ID slot holds a real instruction
- `id_pc`  out  N  address of the instruction in the slot
- `id_instr`  out  32  instruction word in the slot
- `misalign`  out  1  sticky flag: a redirect target had bits [1:0] ≠ 0
- `fetch_count`  out  16  number of instructions issued into IF/ID; wraps at 2^16

## Operation
- **Reset** (`reset`=0 at a rising edge):
  - PC ← `RESET_PC`; state ← BOOT
  - `id_valid` ← 0, `id_pc` ← 0, `id_instr` ← `NOP`
  - `misalign` ← 0, `fetch_count` ← 0
  - Reset overrides every other input.
- **BOOT**: one cycle, no capture; unconditionally → RUN. `id_*` stay at reset values.
- **RUN**, priority highest first:
  1. **Redirect** (`redirect`=1):
     - PC ← {`redirect_pc`[N-1:2], 2'b00}
     - `id_valid` ← 0, `id_instr` ← `NOP`, `id_pc` holds
     - `fetch_count` unchanged
     - If `redirect_pc`[1:0] ≠ 0, `misalign` ← 1
     - Redirect wins over a stall. The instruction currently at the old PC is discarded.
  2. **Stall** (`id_valid`=1 and `id_ready`=0): PC, `id_*` and `fetch_count` hold.
  3. **Advance** (otherwise):
     - `id_pc` ← PC, `id_instr` ← `imem_rdata`, `id_valid` ← 1
     - PC ← PC + 4, modulo 2^N (wraps silently)
     - `fetch_count` ← `fetch_count` + 1, modulo 2^16
- **Handshake**: a transfer to decode occurs on an edge where `id_valid`=1 and `id_ready`=1. `id_ready` is ignored while `id_valid`=0, so an empty slot always fills.
- `misalign` clears only on reset.

## Timing
- All outputs are registered except `imem_addr`, which is the PC register itself (no combinational path from inputs).
- **After reset**: let E1 be the first rising edge with `reset`=1.
  - E1: BOOT → RUN only.
  - E2: first capture, `id_valid`=1, `id_pc`=`RESET_PC`.
- **Throughput**: one instruction per cycle with `id_ready` held high.
- **Redirect penalty**: exactly one bubble.
  - Edge R (redirect sampled): the flush.
  - Edge R+1: `id_pc`=target, `id_valid`=1.
- A redirect held high for k consecutive cycles produces k bubbles; the last target wins.
- `reset`=0 mid-stall or mid-redirect fully discards the in-flight slot at that edge.

## Test plan
- Reset, then release with `id_ready`=1 and imem returning `addr`^32'hA5A5_0000 → at E2 `id_pc`=0; then `id_pc`=4, 8, 12 on successive edges with matching `id_instr`; `fetch_count`=3 after E4.
- Drop `id_ready` for 3 cycles while `id_pc`=8 → `id_pc`, `id_instr`, `imem_addr`=12 and `fetch_count` frozen; on re-assert, next edge gives `id_pc`=12.
- `redirect`=1, `redirect_pc`=0x100 during a stall → next edge `id_valid`=0, `id_instr`=`NOP`; following edge `id_pc`=0x100, `id_valid`=1; `misalign`=0.
- `redirect_pc`=0x203 → PC becomes 0x200, `misalign`=1 and stays 1 through further redirects; cleared only by reset.
- With `N`=8, redirect to 0xF8 → `id_pc` sequence 0xF8, 0xFC, 0x00 (wrap).
- Assert `reset`=0 for one edge while running with `fetch_count`=5 → all outputs return to reset values; release gives the BOOT cycle, then `id_pc`=`RESET_PC`.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the LEGv8 pipeline.
//
// Owns the program counter, drives the instruction-memory address and captures
// the fetched word into the IF/ID register. The PC advances by 4 per issued
// instruction, takes redirects from later stages and holds under back-pressure.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-low
//   imem_addr    instruction-memory address (the PC register itself)
//   imem_rdata   instruction word at imem_addr, same cycle
//   redirect     redirect request from a later stage
//   redirect_pc  redirect target (low two bits dropped, flagged if non-zero)
//   id_ready     decode accepts the IF/ID slot this cycle
//   id_valid     IF/ID slot holds a real instruction
//   id_pc        address of the instruction in the slot
//   id_instr     instruction word in the slot (NOP when empty)
//   misalign     sticky: some redirect target had bits [1:0] != 0
//   fetch_count  instructions issued into IF/ID, wraps at 2^16
//   dbg_state_o  current FSM state (0 = BOOT, 1 = RUN)
//
// Handshake: the slot transfers to decode on a rising edge where
// id_valid=1 and id_ready=1. id_ready is ignored while id_valid=0, so an
// empty slot always fills on the next RUN edge.
module fetch_stage #(
  parameter int              N        = 64,
  parameter logic [N-1:0]    RESET_PC = '0,
  parameter logic [31:0]     NOP      = 32'hD503201F
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] imem_addr,
  input  logic [31:0]  imem_rdata,
  input  logic         redirect,
  input  logic [N-1:0] redirect_pc,
  input  logic         id_ready,
  output logic         id_valid,
  output logic [N-1:0] id_pc,
  output logic [31:0]  id_instr,
  output logic         misalign,
  output logic [15:0]  fetch_count,
  output logic         dbg_state_o
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         id_valid_q, id_valid_d;
  logic [N-1:0] id_pc_q, id_pc_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic         misalign_q, misalign_d;
  logic [15:0]  fetch_count_q, fetch_count_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_instr_d    = id_instr_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect) begin
          // Flush: the word at the old PC is dropped, id_pc keeps its value.
          pc_d       = {redirect_pc[N-1:2], 2'b00};
          id_valid_d = 1'b0;
          id_instr_d = NOP;
          if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (id_valid_q && !id_ready) begin
          // Stall: everything holds.
        end else begin
          id_pc_d       = pc_q;
          id_instr_d    = imem_rdata;
          id_valid_d    = 1'b1;
          pc_d          = pc_q + N'(4);
          fetch_count_d = fetch_count_q + 16'd1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_instr_q    <= NOP;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_instr_q    <= id_instr_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_instr    = id_instr_q;
  assign misalign    = misalign_q;
  assign fetch_count = fetch_count_q;
  assign dbg_state_o = (state_q == RUN);

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a 64-bit instance driven by directed and random
// stimulus against a scoreboard, plus an 8-bit instance for PC wrap-around.
module tb_fetch_stage;

  localparam logic [31:0] NOP_W = 32'hD503201F;
  localparam logic [31:0] XMASK = 32'hA5A5_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 64-bit DUT ----------------
  logic        reset, redirect, id_ready;
  logic [63:0] redirect_pc, imem_addr, id_pc;
  logic [31:0] imem_rdata, id_instr;
  logic        id_valid, misalign, dbg_state;
  logic [15:0] fetch_count;

  assign imem_rdata = imem_addr[31:0] ^ XMASK;

  fetch_stage #(.N(64)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .misalign(misalign), .fetch_count(fetch_count), .dbg_state_o(dbg_state)
  );

  // ---------------- 8-bit DUT (wrap) ----------------
  logic        reset8, redirect8, id_ready8;
  logic [7:0]  redirect_pc8, imem_addr8, id_pc8;
  logic [31:0] imem_rdata8, id_instr8;
  logic        id_valid8, misalign8, dbg_state8;
  logic [15:0] fetch_count8;

  assign imem_rdata8 = {24'h0, imem_addr8} ^ XMASK;

  fetch_stage #(.N(8)) dut8 (
    .clk(clk), .reset(reset8), .imem_addr(imem_addr8), .imem_rdata(imem_rdata8),
    .redirect(redirect8), .redirect_pc(redirect_pc8), .id_ready(id_ready8),
    .id_valid(id_valid8), .id_pc(id_pc8), .id_instr(id_instr8),
    .misalign(misalign8), .fetch_count(fetch_count8), .dbg_state_o(dbg_state8)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [95:0] exp_q[$];   // {pc, instr} of slots issued into IF/ID

  // bench-side expectation of the architectural state
  logic [63:0] m_pc;
  logic        m_run, m_valid, m_mis;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge on the 64-bit DUT. Called at a negedge, returns at a negedge.
  task automatic step(input logic rst, input logic rdy, input logic rd, input logic [63:0] rpc);
    logic        s_valid;
    logic [63:0] s_pc;
    logic [31:0] s_instr;
    logic [95:0] e;
    reset = rst; id_ready = rdy; redirect = rd; redirect_pc = rpc;
    s_valid = id_valid; s_pc = id_pc; s_instr = id_instr;
    @(posedge clk);
    if (!rst) begin
      m_pc = 64'h0; m_run = 1'b0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 16'h0;
      exp_q.delete();
    end else begin
      // slot leaves IF/ID: transferred to decode, or flushed by a redirect
      if (m_valid && (rdy || rd)) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          if (rdy) begin
            check("xfer_valid", {63'h0, s_valid}, 64'h1);
            check("xfer_pc", s_pc, e[95:32]);
            check("xfer_instr", {32'h0, s_instr}, {32'h0, e[31:0]});
          end
        end
      end
      if (!m_run) begin
        m_run = 1'b1;
      end else if (rd) begin
        m_pc = {rpc[63:2], 2'b00};
        m_valid = 1'b0;
        if (rpc[1:0] != 2'b00) m_mis = 1'b1;
      end else if (m_valid && !rdy) begin
        // stall
      end else begin
        exp_q.push_back({m_pc, m_pc[31:0] ^ XMASK});
        m_valid = 1'b1;
        m_pc = m_pc + 64'd4;
        m_cnt = m_cnt + 16'd1;
      end
    end
    #1;
    check("valid", {63'h0, id_valid}, {63'h0, m_valid});
    check("imem_addr", imem_addr, m_pc);
    check("misalign", {63'h0, misalign}, {63'h0, m_mis});
    check("fetch_count", {48'h0, fetch_count}, {48'h0, m_cnt});
    check("state", {63'h0, dbg_state}, {63'h0, m_run});
    if (!m_valid) check("empty_nop", {32'h0, id_instr}, {32'h0, NOP_W});
    @(negedge clk);
  endtask

  task automatic step8(input logic rst, input logic rd, input logic [7:0] rpc);
    reset8 = rst; id_ready8 = 1'b1; redirect8 = rd; redirect_pc8 = rpc;
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; id_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    reset8 = 1'b0; id_ready8 = 1'b1; redirect8 = 1'b0; redirect_pc8 = '0;
    m_pc = '0; m_run = 1'b0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = '0;
    @(negedge clk);

    // reset state
    step(1'b0, 1'b1, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    check("rst_pc", id_pc, 64'h0);
    check("rst_instr", {32'h0, id_instr}, {32'h0, NOP_W});

    // E1: BOOT -> RUN only; E2..E4 sequential capture
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("e1_valid", {63'h0, id_valid}, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("e2_pc", id_pc, 64'h0);
    check("e2_instr", {32'h0, id_instr}, 64'hA5A5_0000);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("e3_pc", id_pc, 64'h4);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("e4_pc", id_pc, 64'h8);
    check("e4_instr", {32'h0, id_instr}, 64'hA5A5_0008);
    check("e4_count", {48'h0, fetch_count}, 64'd3);

    // back-pressure for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 64'h0);
      check("stall_pc", id_pc, 64'h8);
      check("stall_addr", imem_addr, 64'hC);
      check("stall_count", {48'h0, fetch_count}, 64'd3);
    end
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("resume_pc", id_pc, 64'hC);

    // redirect during a stall
    step(1'b1, 1'b0, 1'b1, 64'h100);
    check("redir_valid", {63'h0, id_valid}, 64'h0);
    check("redir_instr", {32'h0, id_instr}, {32'h0, NOP_W});
    check("redir_hold_pc", id_pc, 64'hC);
    step(1'b1, 1'b0, 1'b0, 64'h0);
    check("redir_tgt_pc", id_pc, 64'h100);
    check("redir_tgt_valid", {63'h0, id_valid}, 64'h1);
    check("redir_mis", {63'h0, misalign}, 64'h0);

    // misaligned target, then a sticky flag
    step(1'b1, 1'b1, 1'b1, 64'h203);
    check("mis_addr", imem_addr, 64'h200);
    check("mis_set", {63'h0, misalign}, 64'h1);
    step(1'b1, 1'b1, 1'b1, 64'h300);
    check("mis_sticky", {63'h0, misalign}, 64'h1);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("last_tgt", id_pc, 64'h300);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      logic        r_rd;
      logic [63:0] r_pc;
      r_rd = ($urandom_range(0, 7) == 0);
      r_pc = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0) r_pc[1:0] = 2'b00;
      step(1'b1, 1'($urandom_range(0, 1)), r_rd, r_pc);
    end

    // reset while running with fetch_count=5
    step(1'b0, 1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h0);
    check("pre_rst_count", {48'h0, fetch_count}, 64'd5);
    step(1'b0, 1'b1, 1'b1, 64'h40);
    check("mid_rst_pc", id_pc, 64'h0);
    check("mid_rst_mis", {63'h0, misalign}, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("boot_valid", {63'h0, id_valid}, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("boot_pc", id_pc, 64'h0);
    check("boot_valid2", {63'h0, id_valid}, 64'h1);

    // 8-bit PC wrap
    step8(1'b0, 1'b0, 8'h0);
    step8(1'b1, 1'b0, 8'h0);
    step8(1'b1, 1'b0, 8'h0);
    check("w8_first", {56'h0, id_pc8}, 64'h0);
    step8(1'b1, 1'b1, 8'hF8);
    check("w8_flush", {63'h0, id_valid8}, 64'h0);
    step8(1'b1, 1'b0, 8'h0);
    check("w8_f8", {56'h0, id_pc8}, 64'hF8);
    step8(1'b1, 1'b0, 8'h0);
    check("w8_fc", {56'h0, id_pc8}, 64'hFC);
    step8(1'b1, 1'b0, 8'h0);
    check("w8_00", {56'h0, id_pc8}, 64'h0);
    check("w8_instr", {32'h0, id_instr8}, 64'hA5A5_0000);
    check("w8_addr", {56'h0, imem_addr8}, 64'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
